nz_weight_accum: RTL

Consumes the non-zero address groups produced by the 4-lane non-zero generator and reads the matching weights from a local weight scratchpad. Because input features are binary, each selected weight is simply added into an accumulator. The block delivers one partial sum per feature vector to the PE-row output path through a valid/ready handshake. It sits directly downstream of the non-zero generator in each PE row of the GNNIE weighting stage.

---
 rtl/nz_weight_accum_pkg.sv | 36 +++
 rtl/nz_weight_accum_if.sv | 26 ++
 rtl/nz_weight_accum_lane_adder.sv | 23 ++
 rtl/nz_weight_accum.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/nz_weight_accum_pkg.sv
// Shared constants, FSM state encoding and accumulator clamp helper for the
// non-zero weight accumulator of a GNNIE PE row.
package gnnie_nz_pkg;

  localparam int DIM            = 4;
  localparam int SPAD_WIDTH     = 64;
  localparam int ADDR_WIDTH     = $clog2(SPAD_WIDTH);
  localparam int WEIGHT_WIDTH   = 8;
  localparam int ACC_WIDTH      = 16;
  localparam int LANE_SUM_WIDTH = WEIGHT_WIDTH + $clog2(DIM);
  localparam int POP_WIDTH      = $clog2(DIM) + 1;
  localparam int CNT_WIDTH      = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Clamp a one-bit-wider sum back into the signed accumulator range.
  function automatic logic signed [ACC_WIDTH-1:0] clamp_acc(input logic signed [ACC_WIDTH:0] wide);
    logic signed [ACC_WIDTH-1:0] res;
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      if (wide[ACC_WIDTH]) begin
        res = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        res = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      res = wide[ACC_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/nz_weight_accum_if.sv
// Address-beat input stream and partial-sum output stream of nz_weight_accum.
// master: upstream generator / downstream consumer side; slave: the accumulator.
interface nz_weight_accum_if;
  import gnnie_nz_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [ADDR_WIDTH*DIM-1:0]   in_addr;
  logic [DIM-1:0]              in_lane_vld;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0]        out_nnz;

  modport master (
    output in_valid, in_addr, in_lane_vld, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_nnz
  );

  modport slave (
    input  in_valid, in_addr, in_lane_vld, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_nnz
  );

endinterface

// File: rtl/nz_weight_accum_lane_adder.sv
// nz_lane_adder: combinational signed sum of DIM lane weights plus popcount
// of the lane mask. Lane weights arrive already gated to zero where masked.
module nz_lane_adder
  import gnnie_nz_pkg::*;
(
  input  logic [DIM*WEIGHT_WIDTH-1:0]      lane_w,
  input  logic [DIM-1:0]                   mask,
  output logic signed [LANE_SUM_WIDTH-1:0] sum,
  output logic [POP_WIDTH-1:0]             popcnt
);

  // Sign-extend every lane to the grown width and sum; count mask bits.
  always_comb begin
    sum    = {LANE_SUM_WIDTH{1'b0}};
    popcnt = {POP_WIDTH{1'b0}};
    for (int i = 0; i < DIM; i++) begin
      sum = sum + {{(LANE_SUM_WIDTH-WEIGHT_WIDTH){lane_w[i*WEIGHT_WIDTH+WEIGHT_WIDTH-1]}},
                   lane_w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
      popcnt = popcnt + {{(POP_WIDTH-1){1'b0}}, mask[i]};
    end
  end

endmodule

// File: rtl/nz_weight_accum.sv
// nz_weight_accum: reads the weights selected by each non-zero address beat
// from a local scratchpad and accumulates them into one partial sum per
// feature vector. Optional macro NZ_ACCUM_SAT_EN makes the accumulator
// saturate (and stay clamped) instead of wrapping.
module nz_weight_accum
  import gnnie_nz_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WEIGHT_WIDTH-1:0] wr_data,
  output logic                    wr_err,
  nz_weight_accum_if.slave        bus
);

  state_t                             state_r, state_nx_s;
  logic                               in_ready_r, in_ready_nx_s;
  logic                               out_valid_r, out_valid_nx_s;
  logic                               hs_in_s, hs_out_s;
  logic [WEIGHT_WIDTH-1:0]            spad_r [SPAD_WIDTH];
  logic                               s1_valid_r, s1_last_r;
  logic [DIM*WEIGHT_WIDTH-1:0]        s1_w_r;
  logic [DIM-1:0]                     s1_mask_r;
  logic signed [LANE_SUM_WIDTH-1:0]   beat_sum_s;
  logic [POP_WIDTH-1:0]               beat_pop_s;
  logic signed [ACC_WIDTH-1:0]        acc_r, acc_nx_s;
  logic [CNT_WIDTH-1:0]               cnt_r;
  logic                               wr_err_r;
`ifdef NZ_ACCUM_SAT_EN
  logic                               sat_r, sat_hit_s;
  logic signed [ACC_WIDTH:0]          acc_wide_s;
`endif

  assign hs_in_s  = bus.in_valid & in_ready_r;
  assign hs_out_s = out_valid_r & bus.out_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_in_s) state_nx_s = bus.in_last ? DRAIN : ACCUM;
        else         state_nx_s = IDLE;
      end
      ACCUM: begin
        if (hs_in_s && bus.in_last) state_nx_s = DRAIN;
        else                        state_nx_s = ACCUM;
      end
      DRAIN: begin
        // Stage 1 holds the final beat here; it retires into the accumulator this cycle.
        if (!s1_valid_r || s1_last_r) state_nx_s = OUT;
        else                          state_nx_s = DRAIN;
      end
      OUT: begin
        if (hs_out_s) state_nx_s = IDLE;
        else          state_nx_s = OUT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM output decode, evaluated on the next state so the handshake flags can be registered.
  always_comb begin
    in_ready_nx_s  = 1'b0;
    out_valid_nx_s = 1'b0;
    case (state_nx_s)
      IDLE:    begin in_ready_nx_s = 1'b1; out_valid_nx_s = 1'b0; end
      ACCUM:   begin in_ready_nx_s = 1'b1; out_valid_nx_s = 1'b0; end
      DRAIN:   begin in_ready_nx_s = 1'b0; out_valid_nx_s = 1'b0; end
      OUT:     begin in_ready_nx_s = 1'b0; out_valid_nx_s = 1'b1; end
      default: begin in_ready_nx_s = 1'b0; out_valid_nx_s = 1'b0; end
    endcase
  end

  // Registered handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
    end
  end

  // Weight scratchpad: writes only land while idle; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_r == IDLE)) spad_r[wr_addr] <= wr_data;
  end

  // Sticky flag for writes that arrive while a vector is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               wr_err_r <= 1'b0;
    else if (wr_en && (state_r != IDLE))     wr_err_r <= 1'b1;
  end

  // Stage 1: fetch and mask the lane weights of an accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_w_r     <= {(DIM*WEIGHT_WIDTH){1'b0}};
      s1_mask_r  <= {DIM{1'b0}};
    end else begin
      s1_valid_r <= hs_in_s;
      if (hs_in_s) begin
        s1_last_r <= bus.in_last;
        s1_mask_r <= bus.in_lane_vld;
        for (int i = 0; i < DIM; i++) begin
          s1_w_r[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= bus.in_lane_vld[i] ?
            spad_r[bus.in_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] : {WEIGHT_WIDTH{1'b0}};
        end
      end
    end
  end

  nz_lane_adder u_lane_adder (
    .lane_w (s1_w_r),
    .mask   (s1_mask_r),
    .sum    (beat_sum_s),
    .popcnt (beat_pop_s)
  );

`ifdef NZ_ACCUM_SAT_EN
  // Stage 2 update with saturation; once clamped the sum is frozen for the vector.
  always_comb begin
    acc_wide_s = {acc_r[ACC_WIDTH-1], acc_r} +
                 {{(ACC_WIDTH+1-LANE_SUM_WIDTH){beat_sum_s[LANE_SUM_WIDTH-1]}}, beat_sum_s};
    sat_hit_s  = (acc_wide_s[ACC_WIDTH] != acc_wide_s[ACC_WIDTH-1]);
    if (sat_r) acc_nx_s = acc_r;
    else       acc_nx_s = clamp_acc(acc_wide_s);
  end

  // Saturation latch, cleared with the accumulator when the result is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         sat_r <= 1'b0;
    else if (hs_out_s)                 sat_r <= 1'b0;
    else if (s1_valid_r && sat_hit_s)  sat_r <= 1'b1;
  end
`else
  // Stage 2 update with two's-complement wrap.
  always_comb begin
    acc_nx_s = acc_r + {{(ACC_WIDTH-LANE_SUM_WIDTH){beat_sum_s[LANE_SUM_WIDTH-1]}}, beat_sum_s};
  end
`endif

  // Stage 2: accumulator and lane count, cleared when the result is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= {ACC_WIDTH{1'b0}};
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (hs_out_s) begin
      acc_r <= {ACC_WIDTH{1'b0}};
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (s1_valid_r) begin
      acc_r <= acc_nx_s;
      cnt_r <= cnt_r + {{(CNT_WIDTH-POP_WIDTH){1'b0}}, beat_pop_s};
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_nnz   = cnt_r;
  assign wr_err        = wr_err_r;

endmodule
